// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, combinational imem access, small fetch FIFO to decode.
// Optional macro FETCH_MISALIGN_CHK_EN: flags misaligned redirect targets and halts fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc_reg;
  logic [31:0]   redirect_target;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  logic          fetch_halted;
  logic          push;
  logic          pop;
  logic          push_misalign;
  logic [31:0]   push_instr;

  logic [31:0]   ent_pc_reg    [FIFO_DEPTH];
  logic [31:0]   ent_instr_reg [FIFO_DEPTH];

`ifdef FETCH_MISALIGN_CHK_EN
  logic          halt_reg;
  logic          ent_mis_reg   [FIFO_DEPTH];

  assign fetch_halted    = halt_reg;
  assign redirect_target = redirect_pc;
  assign push_misalign   = (pc_reg[1:0] != 2'b00);
`else
  logic          unused_redirect_lsb;

  assign fetch_halted        = 1'b0;
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign push_misalign       = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  assign imem_addr  = pc_reg;
  assign id_valid   = (count_reg != '0);
  assign push_instr = push_misalign ? NOP : imem_instr;

  // Push never looks at id_ready, so there is no decode -> imem_addr path.
  assign push = !redirect_valid && (count_reg < DEPTH_C) && !fetch_halted;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (PW + 1)'(1);
      2'b01:   count_next = count_reg - (PW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg     <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      halt_reg   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_reg     <= redirect_target;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      halt_reg   <= 1'b0;
`endif
    end else begin
      count_reg <= count_next;
      if (push) begin
        pc_reg     <= pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
`ifdef FETCH_MISALIGN_CHK_EN
        if (push_misalign) halt_reg <= 1'b1;
`endif
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Entry contents need no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ent_pc_reg[wr_ptr_reg]    <= pc_reg;
      ent_instr_reg[wr_ptr_reg] <= push_instr;
`ifdef FETCH_MISALIGN_CHK_EN
      ent_mis_reg[wr_ptr_reg]   <= push_misalign;
`endif
    end
  end

  always_comb begin
    id_instr    = 32'h0;
    id_pc       = 32'h0;
    id_pc_plus4 = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
    id_misalign = 1'b0;
`endif
    if (id_valid) begin
      id_instr    = ent_instr_reg[rd_ptr_reg];
      id_pc       = ent_pc_reg[rd_ptr_reg];
      id_pc_plus4 = ent_pc_reg[rd_ptr_reg] + 32'd4;
`ifdef FETCH_MISALIGN_CHK_EN
      id_misalign = ent_mis_reg[rd_ptr_reg];
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random stimulus against a queue model.
// Honours FETCH_MISALIGN_CHK_EN when defined for both DUT and model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_misalign;
`endif

  always #5 clk = ~clk;

  // imem word i holds i+1
  assign imem_instr = (imem_addr >> 2) + 32'd1;

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .id_misalign    (id_misalign)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_mis;
    e_pc = 0; e_instr = 0; e_p4 = 0; e_mis = 0;
    if (m_q.size() > 0) begin
      e_pc    = m_q[0].pc;
      e_instr = m_q[0].instr;
      e_p4    = m_q[0].pc + 32'd4;
      e_mis   = m_q[0].mis;
    end
    check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() > 0});
    check("id_pc", id_pc, e_pc);
    check("id_instr", id_instr, e_instr);
    check("id_pc_plus4", id_pc_plus4, e_p4);
    check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_MISALIGN_CHK_EN
    check("id_misalign", {31'b0, id_misalign}, {31'b0, e_mis});
`else
    if (e_mis) check("model_mis", 32'd1, 32'd0);
`endif
  endtask

  // Check current outputs, apply one cycle of inputs, advance model and DUT.
  task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    ent_t e;
    bit   do_push, do_pop;
    check_outputs();
    rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    if (!r) begin
      m_q.delete(); m_pc = RESET_PC; m_halt = 0;
    end else if (rv) begin
      m_q.delete(); m_halt = 0;
`ifdef FETCH_MISALIGN_CHK_EN
      m_pc = rpc;
`else
      m_pc = rpc & ~32'h3;
`endif
    end else begin
      do_push = (m_q.size() < DEPTH) && !m_halt;
      do_pop  = (m_q.size() > 0) && rdy;
      if (do_pop) begin
        $display("xfer pc=%08h instr=%08h", m_q[0].pc, m_q[0].instr);
        void'(m_q.pop_front());
      end
      if (do_push) begin
        e.pc = m_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        e.mis = (m_pc[1:0] != 2'b00);
`else
        e.mis = 1'b0;
`endif
        e.instr = e.mis ? 32'h0000_0013 : (m_pc >> 2) + 32'd1;
        m_q.push_back(e);
        if (e.mis) m_halt = 1;
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_q.delete(); m_pc = RESET_PC; m_halt = 0;

    // 1: streaming after reset
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1);

    // 2: back-pressure from reset, FIFO saturates with imem_addr at 8
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    check("stall_addr", imem_addr, 32'h8);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

    // 3: redirect while full
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 32'h40, 0);
    check("redir_flush", {31'b0, id_valid}, 32'd0);
    cycle(1, 0, 0, 0);
    check("redir_pc", id_pc, 32'h40);
    check("redir_p4", id_pc_plus4, 32'h44);

    // 4: redirect with id_ready high
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h100, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

    // 5: one-cycle reset mid-stream
    cycle(0, 0, 0, 1);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);

    // 6: misaligned redirect, then wrap
    cycle(1, 1, 32'h42, 0);
    cycle(1, 0, 0, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_pc", id_pc, 32'h42);
    check("mis_instr", id_instr, 32'h13);
`else
    check("mis_pc", id_pc, 32'h40);
`endif
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'hFFFF_FFFC, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("wrap_pc", id_pc, 32'h0);

    // random
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(3))
        0:       rpc = 32'($urandom_range(63)) << 2;
        1:       rpc = $urandom;
        2:       rpc = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
        default: rpc = $urandom & ~32'h3;
      endcase
      cycle($urandom_range(99) >= 3, $urandom_range(99) < 8, rpc, $urandom_range(99) < 65);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
